// File: rtl/i2c_reg_arb_pkg.sv
// i2c_reg_arb_pkg: shared FSM encodings, port indices and timeout read value for i2c_reg_arbiter.
package i2c_reg_arb_pkg;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic       PORT0     = 1'b0;
    localparam logic       PORT1     = 1'b1;
    localparam logic [7:0] ERR_RDATA = 8'hFF;
endpackage

// File: rtl/i2c_reg_arbiter_if.sv
// i2c_reg_arbiter_if: two requester ports, the shared register-bank port and busy status.
interface i2c_reg_arbiter_if #(
    parameter int P_ADDR_W = 8
);
    logic                s0_en, s0_wr, s0_ack, s0_err;
    logic                s1_en, s1_wr, s1_ack, s1_err;
    logic [P_ADDR_W-1:0] s0_addr, s1_addr, m_addr;
    logic [7:0]          s0_wdata, s1_wdata, s0_rdata, s1_rdata;
    logic                m_en, m_wr, m_ack, busy;
    logic [7:0]          m_wdata, m_rdata;
    modport slave (
        input  s0_en, s0_wr, s0_addr, s0_wdata, s1_en, s1_wr, s1_addr, s1_wdata, m_rdata, m_ack,
        output s0_rdata, s0_ack, s0_err, s1_rdata, s1_ack, s1_err, m_en, m_wr, m_addr, m_wdata, busy
    );
    modport master (
        output s0_en, s0_wr, s0_addr, s0_wdata, s1_en, s1_wr, s1_addr, s1_wdata, m_rdata, m_ack,
        input  s0_rdata, s0_ack, s0_err, s1_rdata, s1_ack, s1_err, m_en, m_wr, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/i2c_reg_arb_timer.sv
// i2c_reg_arb_timer: BUSY-cycle counter that flags expiry on the cycle it would reach P_TIMEOUT.
module i2c_reg_arb_timer #(
    parameter int P_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);
    localparam int W = $clog2(P_TIMEOUT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign cnt_d    = clr_i ? '0 : cnt_q + W'(inc_i);
    assign expire_o = inc_i && (int'(cnt_q) + 1 == P_TIMEOUT);
    always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter: two-port arbiter onto a shared register bank with a bank-ack timeout.
// Define I2C_REG_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins ties.
module i2c_reg_arbiter
    import i2c_reg_arb_pkg::*;
#(
    parameter int P_ADDR_W  = 8,
    parameter int P_TIMEOUT = 15
) (
    input logic              clk,
    input logic              rst_n,
    i2c_reg_arbiter_if.slave bus
);
    logic [1:0]          state_q, state_d;
    logic                gnt_q, gnt_d, win, req, fin, expire;
    logic                m_en_q, m_en_d, m_wr_q, m_wr_d;
    logic [P_ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [7:0]          m_wdata_q, m_wdata_d;
    logic [1:0][7:0]     rdata_q, rdata_d;
    logic [1:0]          ack_q, ack_d, err_q, err_d;
    assign req = bus.s0_en | bus.s1_en;
    assign fin = state_q == S_BUSY && (bus.m_ack || expire);
`ifdef I2C_REG_ARB_RR_EN
    logic last_q;
    assign win = (bus.s0_en & bus.s1_en) ? ~last_q : (bus.s0_en ? PORT0 : PORT1);
    always_ff @(posedge clk)
        last_q <= !rst_n ? PORT1 : ((state_q == S_IDLE && req) ? win : last_q);
`else
    assign win = bus.s0_en ? PORT0 : PORT1;
`endif
    i2c_reg_arb_timer #(.P_TIMEOUT(P_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (state_q != S_BUSY),
        .inc_i   (state_q == S_BUSY && !bus.m_ack),
        .expire_o(expire)
    );
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        m_en_d    = m_en_q;
        m_wr_d    = m_wr_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ack_d     = '0;
        if (state_q == S_IDLE && req) begin
            state_d   = S_BUSY;
            gnt_d     = win;
            m_en_d    = 1'b1;
            m_wr_d    = win ? bus.s1_wr : bus.s0_wr;
            m_addr_d  = win ? bus.s1_addr : bus.s0_addr;
            m_wdata_d = win ? bus.s1_wdata : bus.s0_wdata;
        end else if (fin) begin
            // a late m_ack coinciding with expiry still counts as success
            state_d        = S_DONE;
            m_en_d         = 1'b0;
            ack_d[gnt_q]   = 1'b1;
            err_d[gnt_q]   = ~bus.m_ack;
            rdata_d[gnt_q] = bus.m_ack ? (m_wr_q ? rdata_q[gnt_q] : bus.m_rdata) : ERR_RDATA;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= PORT0;
            m_en_q    <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            rdata_q   <= '0;
            ack_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            m_en_q    <= m_en_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end
    assign bus.m_en     = m_en_q;
    assign bus.m_wr     = m_wr_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.s0_rdata = rdata_q[PORT0];
    assign bus.s1_rdata = rdata_q[PORT1];
    assign bus.s0_ack   = ack_q[PORT0];
    assign bus.s1_ack   = ack_q[PORT1];
    assign bus.s0_err   = err_q[PORT0];
    assign bus.s1_err   = err_q[PORT1];
    assign bus.busy     = state_q != S_IDLE;
endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// tb_i2c_reg_arbiter: directed vector table, multi-cycle hand sequences and random transactions
// checked against a transaction-level model (grant history, per-port read-back values).
module tb_i2c_reg_arbiter;
    localparam int TO = 15;
`ifdef I2C_REG_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct {
        logic       e0, e1, w0, w1;
        logic [7:0] a0, a1, d0, d1;
        int         lat;
        logic [7:0] rd;
        int         ewin, ecyc;
        logic       eerr;
        logic [7:0] erd;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    i2c_reg_arbiter_if #(.P_ADDR_W(8)) bus ();
    i2c_reg_arbiter #(.P_ADDR_W(8), .P_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] mdl_rd [2];
    int         hist [$];
    vec_t       tbl [9];
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    function automatic vec_t mk(logic e0, logic e1, logic w0, logic w1, logic [7:0] a0, logic [7:0] a1,
                                logic [7:0] d0, logic [7:0] d1, int lat, logic [7:0] rd,
                                int ewin, int ecyc, logic eerr, logic [7:0] erd);
        vec_t v;
        v.e0 = e0; v.e1 = e1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.lat = lat; v.rd = rd;
        v.ewin = ewin; v.ecyc = ecyc; v.eerr = eerr; v.erd = erd;
        return v;
    endfunction
    // Transaction-level model: winner from grant history, m_en length from ack latency.
    function automatic void predict(inout vec_t v);
        int  w;
        logic wr;
        if (v.e0 && v.e1) w = (RR && hist.size() > 0) ? 1 - hist[$] : 0;
        else w = v.e1 ? 1 : 0;
        wr = (w == 1) ? v.w1 : v.w0;
        v.ewin = w;
        v.ecyc = (v.lat > TO) ? TO : v.lat;
        v.eerr = v.lat > TO;
        v.erd  = v.eerr ? 8'hFF : (wr ? mdl_rd[w] : v.rd);
    endfunction
    task automatic txn(input vec_t v, output int gwin, output int gcyc, output logic gerr,
                       output logic [7:0] grd, output bit lat_ok, output bit mok,
                       output bit done_ok, output bit idle_ok);
        bus.s0_en = v.e0; bus.s0_wr = v.w0; bus.s0_addr = v.a0; bus.s0_wdata = v.d0;
        bus.s1_en = v.e1; bus.s1_wr = v.w1; bus.s1_addr = v.a1; bus.s1_wdata = v.d1;
        bus.m_ack = 1'b0;
        step();
        lat_ok = bus.m_en;
        gwin = -1; gcyc = 0; mok = 1'b1; gerr = 1'b0; grd = 8'h00;
        for (int c = 0; c < 40 && gwin < 0; c++) begin
            if (bus.s0_ack || bus.s1_ack) begin
                gwin = (bus.s0_ack && bus.s1_ack) ? 2 : (bus.s1_ack ? 1 : 0);
                gerr = bus.s1_ack ? bus.s1_err : bus.s0_err;
                grd  = bus.s1_ack ? bus.s1_rdata : bus.s0_rdata;
            end else begin
                if (bus.m_en) begin
                    gcyc++;
                    if (bus.m_wr !== ((v.ewin == 1) ? v.w1 : v.w0) ||
                        bus.m_addr !== ((v.ewin == 1) ? v.a1 : v.a0) ||
                        bus.m_wdata !== ((v.ewin == 1) ? v.d1 : v.d0)) mok = 1'b0;
                end
                bus.m_ack   = bus.m_en && gcyc == v.lat;
                bus.m_rdata = bus.m_ack ? v.rd : 8'($urandom);
                if (c == 0) begin
                    bus.s0_en = 1'b0; bus.s1_en = 1'b0;
                    bus.s0_wr = 1'($urandom); bus.s1_wr = 1'($urandom);
                    bus.s0_addr = 8'($urandom); bus.s1_addr = 8'($urandom);
                    bus.s0_wdata = 8'($urandom); bus.s1_wdata = 8'($urandom);
                end
                step();
            end
        end
        done_ok = bus.busy && !bus.m_en;
        bus.m_ack = 1'b1;
        bus.m_rdata = 8'h77;
        step();
        idle_ok = !bus.busy && !bus.m_en && !bus.s0_ack && !bus.s1_ack;
        bus.m_ack = 1'b0;
    endtask
    task automatic apply(input vec_t v);
        int gwin, gcyc;
        logic gerr;
        logic [7:0] grd;
        bit lat_ok, mok, done_ok, idle_ok;
        txn(v, gwin, gcyc, gerr, grd, lat_ok, mok, done_ok, idle_ok);
        check("grant", longint'(gwin), longint'(v.ewin));
        check("men_cycles", longint'(gcyc), longint'(v.ecyc));
        check("err", longint'(gerr), longint'(v.eerr));
        check("ack_rdata", longint'(grd), longint'(v.erd));
        check("latency", longint'(lat_ok), 64'd1);
        check("m_hold", longint'(mok), 64'd1);
        check("done_state", longint'(done_ok), 64'd1);
        check("idle_after_done", longint'(idle_ok), 64'd1);
        mdl_rd[v.ewin[0]] = v.erd;
        hist.push_back(v.ewin);
        check("rdata0", longint'(bus.s0_rdata), longint'(mdl_rd[0]));
        check("rdata1", longint'(bus.s1_rdata), longint'(mdl_rd[1]));
    endtask
    function automatic longint all_out();
        return longint'({bus.m_en, bus.m_wr, bus.m_addr, bus.m_wdata, bus.s0_rdata, bus.s1_rdata,
                         bus.s0_ack, bus.s1_ack, bus.s0_err, bus.s1_err, bus.busy});
    endfunction
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end
    initial begin
        int acks;
        bus.s0_en = 0; bus.s0_wr = 0; bus.s0_addr = 0; bus.s0_wdata = 0;
        bus.s1_en = 0; bus.s1_wr = 0; bus.s1_addr = 0; bus.s1_wdata = 0;
        bus.m_ack = 0; bus.m_rdata = 0;
        mdl_rd[0] = 8'h00; mdl_rd[1] = 8'h00;
        tbl[0] = mk(1, 1, 0, 1, 8'h01, 8'h81, 8'h00, 8'h99, 2, 8'h11, 0, 2, 0, 8'h11);
        tbl[1] = mk(1, 1, 0, 1, 8'h01, 8'h81, 8'h00, 8'h99, 3, 8'h22, RR ? 1 : 0, 3, 0, RR ? 8'h00 : 8'h22);
        tbl[2] = mk(1, 1, 0, 1, 8'h01, 8'h81, 8'h00, 8'h99, 1, 8'h33, 0, 1, 0, 8'h33);
        tbl[3] = mk(1, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00, 4, 8'hA5, 0, 4, 0, 8'hA5);
        tbl[4] = mk(0, 1, 0, 1, 8'h00, 8'h20, 8'h00, 8'h3C, 99, 8'h00, 1, 15, 1, 8'hFF);
        tbl[5] = mk(1, 0, 0, 0, 8'h30, 8'h00, 8'h00, 8'h00, 15, 8'h5A, 0, 15, 0, 8'h5A);
        tbl[6] = mk(0, 1, 0, 0, 8'h00, 8'h40, 8'h00, 8'h00, 16, 8'hEE, 1, 15, 1, 8'hFF);
        tbl[7] = mk(0, 1, 0, 0, 8'h00, 8'h41, 8'h00, 8'h00, 1, 8'hC3, 1, 1, 0, 8'hC3);
        tbl[8] = mk(1, 0, 1, 0, 8'h50, 8'h00, 8'hD7, 8'h00, 5, 8'h99, 0, 5, 0, 8'h5A);
        repeat (3) step();
        check("reset_outputs", all_out(), 64'd0);
        rst_n = 1'b1;
        foreach (tbl[i]) apply(tbl[i]);
        // Requester holds en through its ack: no re-grant until IDLE has been seen.
        bus.s0_en = 1; bus.s0_wr = 0; bus.s0_addr = 8'h42; bus.s1_en = 0;
        step();
        check("hold_men", longint'(bus.m_en), 64'd1);
        bus.m_ack = 1; bus.m_rdata = 8'h6B;
        step();
        check("hold_ack", longint'({bus.s0_ack, bus.s1_ack, bus.s0_rdata}), 64'h26B);
        check("hold_done", longint'({bus.busy, bus.m_en}), 64'h2);
        bus.m_ack = 0;
        step();
        check("hold_idle", longint'({bus.busy, bus.m_en, bus.s0_ack}), 64'h0);
        step();
        check("hold_regrant", longint'(bus.m_en), 64'd1);
        bus.s0_en = 0; bus.m_ack = 1; bus.m_rdata = 8'h6C;
        step();
        check("hold_ack2", longint'({bus.s0_ack, bus.s0_err, bus.s0_rdata}), 64'h26C);
        bus.m_ack = 0;
        step();
        mdl_rd[0] = 8'h6C;
        hist.push_back(0);
        hist.push_back(0);
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            int r;
            r = int'($urandom_range(1, 3));
            v.e0 = r[0]; v.e1 = r[1];
            v.w0 = 1'($urandom); v.w1 = 1'($urandom);
            v.a0 = 8'($urandom); v.a1 = 8'($urandom);
            v.d0 = 8'($urandom); v.d1 = 8'($urandom);
            v.lat = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(1, 17));
            v.rd = 8'($urandom);
            predict(v);
            apply(v);
        end
        // Reset in the second BUSY cycle aborts the access with no ack.
        bus.s1_en = 1; bus.s1_wr = 1; bus.s1_addr = 8'h66; bus.s1_wdata = 8'h12; bus.s0_en = 0;
        step();
        check("rst_men1", longint'(bus.m_en), 64'd1);
        step();
        rst_n = 1'b0;
        bus.s1_en = 0;
        step();
        check("rst_midbusy_outputs", all_out(), 64'd0);
        rst_n = 1'b1;
        bus.m_ack = 1;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            acks += int'(bus.s0_ack) + int'(bus.s1_ack) + int'(bus.m_en);
        end
        check("rst_no_ack", longint'(acks), 64'd0);
        bus.m_ack = 0;
        mdl_rd[0] = 8'h00; mdl_rd[1] = 8'h00;
        hist.delete();
        apply(mk(0, 1, 0, 0, 8'h00, 8'h77, 8'h00, 8'h00, 3, 8'h4D, 1, 3, 0, 8'h4D));
        apply(mk(1, 1, 0, 0, 8'h05, 8'h06, 8'h00, 8'h00, 2, 8'h3E, RR ? 0 : 0, 2, 0, 8'h3E));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
